// File: rtl/flexp_bfloat16.sv
// flexp_bfloat16 - base-2 antilog unit for bfloat16, res = 2^x.
//
// The operand is turned into 22-bit fixed point (binary point at bit 14).
// The integer part I becomes the result exponent. The fraction F drives a
// bit-serial product of constants 2^(2^-k), one multiply per ITER cycle.
// Only one operation is in flight, with a valid/ready handshake on each side.
//
// Parameters:
//   N_IT       fraction bits consumed, one per ITER cycle (1..14)
//   ACC_WIDTH  width of the Q1.15 product accumulator (16)
//
// Ports:
//   clk_i     clock
//   rst_i     asynchronous active-high reset
//   valid_i   operand valid
//   ready_o   unit can accept an operand (IDLE only)
//   op_i      bfloat16 operand x
//   valid_o   result valid
//   ready_i   consumer accepts result
//   res_o     bfloat16 result
//   status_o  {invalid, overflow, underflow}, valid with valid_o
//
// Build option:
//   FLEXP_ROUND_EN  defined: PACK rounds the mantissa to nearest.
//                   undefined: PACK truncates the mantissa.

module flexp_bfloat16 #(
  parameter int N_IT      = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [15:0] op_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [15:0] res_o,
  output logic [2:0]  status_o
);

  typedef enum logic [2:0] {IDLE, CONV, ITER, PACK, DONE} state_t;

  localparam logic [3:0]           K_LAST  = 4'(N_IT);
  localparam int                   C_SHIFT = ACC_WIDTH - 16;
  localparam logic [ACC_WIDTH-1:0] A_ONE   = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t state_q, state_d;

  logic [15:0]          op_q;
  logic [7:0]           i_q;
  logic [13:0]          f_q;
  logic [ACC_WIDTH-1:0] a_q;
  logic [3:0]           k_q;
  logic                 special_q;
  logic [15:0]          res_q;
  logic [2:0]           status_q;

  // C_k = round(2^(2^-k) * 2^15)
  function automatic logic [15:0] exp_const(input logic [3:0] k);
    case (k)
      4'd1:    return 16'hB505;
      4'd2:    return 16'h9838;
      4'd3:    return 16'h8B96;
      4'd4:    return 16'h85AB;
      4'd5:    return 16'h82CE;
      4'd6:    return 16'h8165;
      4'd7:    return 16'h80B2;
      4'd8:    return 16'h8059;
      4'd9:    return 16'h802C;
      4'd10:   return 16'h8016;
      4'd11:   return 16'h800B;
      4'd12:   return 16'h8006;
      4'd13:   return 16'h8003;
      4'd14:   return 16'h8001;
      default: return 16'h8000;
    endcase
  endfunction

  // Operand fields
  logic       sign;
  logic [7:0] expo;
  logic [6:0] mant;
  assign sign = op_q[15];
  assign expo = op_q[14:7];
  assign mant = op_q[6:0];

  // Special-case decode
  logic        spec_hit;
  logic [15:0] spec_res;
  logic [2:0]  spec_status;

  always_comb begin
    spec_hit    = 1'b1;
    spec_res    = '0;
    spec_status = '0;
    if (expo == 8'hFF) begin
      if (mant != 7'd0) begin
        spec_res    = 16'h7FC0;
        spec_status = 3'b100;
      end else if (!sign) begin
        spec_res = 16'h7F80;
      end
    end else if (expo == 8'h00) begin
      spec_res = 16'h3F80;
    end else if (expo >= 8'd134) begin
      if (!sign) begin
        spec_res    = 16'h7F80;
        spec_status = 3'b010;
      end else begin
        spec_status = 3'b001;
      end
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Fixed-point conversion: leading 1 of {1,m} placed at bit 14, then scaled
  logic [21:0] base;
  logic [21:0] fx_mag;
  logic [21:0] fx;

  always_comb begin
    base   = {7'd0, 1'b1, mant, 7'd0};
    fx_mag = '0;
    if (expo >= 8'd127) begin
      fx_mag = base << (expo - 8'd127);
    end else if ((8'd127 - expo) < 8'd15) begin
      fx_mag = base >> (8'd127 - expo);
    end
    fx = sign ? -fx_mag : fx_mag;
  end

  // One constant multiply per ITER cycle
  logic [ACC_WIDTH-1:0]   c_k;
  logic [2*ACC_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]   a_mul;

  assign c_k   = ACC_WIDTH'(exp_const(k_q)) << C_SHIFT;
  assign prod  = (2*ACC_WIDTH)'(a_q) * (2*ACC_WIDTH)'(c_k);
  assign a_mul = prod[2*ACC_WIDTH-2 -: ACC_WIDTH];

  // Result packing
  logic [8:0]  e_biased;
  logic [15:0] pack_res;
  logic [2:0]  pack_status;
`ifdef FLEXP_ROUND_EN
  logic [7:0]  mant_r;
  logic [8:0]  e_round;
`endif

  always_comb begin
    e_biased    = {i_q[7], i_q} + 9'd127;
    pack_res    = '0;
    pack_status = '0;
`ifdef FLEXP_ROUND_EN
    mant_r  = '0;
    e_round = e_biased;
`endif
    if (e_biased[8] || (e_biased == 9'd0)) begin
      pack_status = 3'b001;
    end else begin
`ifdef FLEXP_ROUND_EN
      // A mantissa carry leaves mant_r[6:0] at zero and bumps the exponent
      mant_r  = {1'b0, a_q[ACC_WIDTH-2 -: 7]} + {7'd0, a_q[ACC_WIDTH-9]};
      e_round = mant_r[7] ? e_biased + 9'd1 : e_biased;
      if (e_round == 9'd255) begin
        pack_res    = 16'h7F80;
        pack_status = 3'b010;
      end else begin
        pack_res = {1'b0, e_round[7:0], mant_r[6:0]};
      end
`else
      pack_res = {1'b0, e_biased[7:0], a_q[ACC_WIDTH-2 -: 7]};
`endif
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Special cases take one pass-through cycle in PACK so their result is
  // presented two edges after accept.
  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_d = CONV;
      end
      CONV:    state_d = spec_hit ? PACK : ITER;
      ITER:    if (k_q == K_LAST) state_d = PACK;
      PACK:    state_d = DONE;
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q      <= '0;
      i_q       <= '0;
      f_q       <= '0;
      a_q       <= A_ONE;
      k_q       <= 4'd1;
      special_q <= 1'b0;
      res_q     <= '0;
      status_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (valid_i) op_q <= op_i;
        CONV: begin
          special_q <= spec_hit;
          a_q       <= A_ONE;
          k_q       <= 4'd1;
          i_q       <= fx[21:14];
          f_q       <= fx[13:0];
          if (spec_hit) begin
            res_q    <= spec_res;
            status_q <= spec_status;
          end
        end
        ITER: begin
          // f_q shifts left so bit 13 is always F[14-k]
          if (f_q[13]) a_q <= a_mul;
          f_q <= f_q << 1;
          k_q <= k_q + 4'd1;
        end
        PACK: begin
          if (!special_q) begin
            res_q    <= pack_res;
            status_q <= pack_status;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign res_o    = res_q;
  assign status_o = status_q;

  logic unused_bits;
  assign unused_bits = ^{prod, a_q};

endmodule

// File: tb/tb_flexp_bfloat16.sv
module tb_flexp_bfloat16;

  localparam int N_IT     = 8;
  localparam int LAT_NORM = N_IT + 2;
  localparam int LAT_SPEC = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] op_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] res_o;
  logic [2:0]  status_o;

  flexp_bfloat16 #(.N_IT(N_IT), .ACC_WIDTH(16)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .res_o   (res_o),
    .status_o(status_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] op;
    logic [15:0] res;
    logic [2:0]  st;
    int          lat;
    string       name;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  st;
    int          lat;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [15:0] op, input logic [15:0] res,
                              input logic [2:0] st, input int lat, input string name);
    vec_t v;
    v.op = op; v.res = res; v.st = st; v.lat = lat; v.name = name;
    vecs.push_back(v);
  endfunction

  function automatic exp_t mk(input logic [15:0] res, input logic [2:0] st,
                              input int lat, input string name);
    exp_t e;
    e.res = res; e.st = st; e.lat = lat; e.name = name;
    return e;
  endfunction

  // Drive one operand; the expected result goes to the scoreboard at accept.
  task automatic issue(input logic [15:0] op, input exp_t e);
    int w;
    w = 0;
    @(negedge clk);
    while (!ready_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({e.name, ":ready_o"}, 32'(ready_o), 32'd1);
    op_i    = op;
    valid_i = 1'b1;
    @(posedge clk);
    sb.push_back(e);
    #1;
    valid_i = 1'b0;
    op_i    = '0;
  endtask

  // Wait (bounded) for valid_o, then pop and compare.
  task automatic collect();
    exp_t e;
    int   lat;
    lat = 0;
    while (lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (valid_o) break;
    end
    check("sb_size", sb.size(), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({e.name, ":valid_o"}, 32'(valid_o), 32'd1);
    check({e.name, ":res_o"}, 32'(res_o), 32'(e.res));
    check({e.name, ":status_o"}, 32'(status_o), 32'(e.st));
    check({e.name, ":latency"}, lat, e.lat);
  endtask

  task automatic handshake(input string name);
    @(posedge clk);
    #1;
    check({name, ":idle_ready_o"}, 32'(ready_o), 32'd1);
    check({name, ":idle_valid_o"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    op_i    = '0;

    add(16'h3F80, 16'h4000, 3'b000, LAT_NORM, "one");
    add(16'h3F00, 16'h3FB5, 3'b000, LAT_NORM, "half");
    add(16'hBF80, 16'h3F00, 3'b000, LAT_NORM, "neg_one");
    add(16'h4000, 16'h4080, 3'b000, LAT_NORM, "two");
    add(16'h3E80, 16'h3F98, 3'b000, LAT_NORM, "quarter");
    add(16'h3F40, 16'h3FD7, 3'b000, LAT_NORM, "three_quarter");
    add(16'hBF00, 16'h3F35, 3'b000, LAT_NORM, "neg_half");
    add(16'h3FC0, 16'h4035, 3'b000, LAT_NORM, "one_p5");
    add(16'h3E00, 16'h3F8B, 3'b000, LAT_NORM, "eighth");
    add(16'h3D80, 16'h3F85, 3'b000, LAT_NORM, "sixteenth");
    add(16'h3FFF, 16'h407E, 3'b000, LAT_NORM, "x_1p992");
    add(16'h3F7F, 16'h3FFF, 3'b000, LAT_NORM, "x_0p996");
    add(16'h3C00, 16'h3F80, 3'b000, LAT_NORM, "tiny");
    add(16'h7FC1, 16'h7FC0, 3'b100, LAT_SPEC, "nan");
    add(16'hFFC0, 16'h7FC0, 3'b100, LAT_SPEC, "nan_neg");
    add(16'h7F80, 16'h7F80, 3'b000, LAT_SPEC, "pos_inf");
    add(16'hFF80, 16'h0000, 3'b000, LAT_SPEC, "neg_inf");
    add(16'h8000, 16'h3F80, 3'b000, LAT_SPEC, "neg_zero");
    add(16'h0001, 16'h3F80, 3'b000, LAT_SPEC, "subnormal");
    add(16'h4300, 16'h7F80, 3'b010, LAT_SPEC, "pos_128");
    add(16'hC300, 16'h0000, 3'b001, LAT_SPEC, "neg_128");
    add(16'hC2FE, 16'h0000, 3'b001, LAT_NORM, "neg_127");
    add(16'h42FE, 16'h7F00, 3'b000, LAT_NORM, "pos_127");
    add(16'h42FD, 16'h7EB5, 3'b000, LAT_NORM, "pos_126p5");
    add(16'hC2FC, 16'h0080, 3'b000, LAT_NORM, "neg_126");
    add(16'hC2FD, 16'h0000, 3'b001, LAT_NORM, "neg_126p5");

    repeat (2) @(posedge clk);
    #1;
    check("reset:ready_o", 32'(ready_o), 32'd1);
    check("reset:valid_o", 32'(valid_o), 32'd0);
    check("reset:res_o", 32'(res_o), 32'h0);
    check("reset:status_o", 32'(status_o), 32'h0);
    @(negedge clk);
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].op, mk(vecs[i].res, vecs[i].st, vecs[i].lat, vecs[i].name));
      collect();
      handshake(vecs[i].name);
    end

    // Backpressure: result held, ready_o low, valid_i pulses ignored
    ready_i = 1'b0;
    issue(16'h3F80, mk(16'h4000, 3'b000, LAT_NORM, "bp_one"));
    collect();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      valid_i = 1'b1;
      op_i    = 16'h4300;
      @(posedge clk);
      #1;
      check("bp:valid_o", 32'(valid_o), 32'd1);
      check("bp:ready_o", 32'(ready_o), 32'd0);
      check("bp:res_o", 32'(res_o), 32'h4000);
      check("bp:status_o", 32'(status_o), 32'h0);
    end
    @(negedge clk);
    valid_i = 1'b0;
    op_i    = '0;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release:valid_o", 32'(valid_o), 32'd0);
    check("bp_release:ready_o", 32'(ready_o), 32'd1);
    issue(16'h3F00, mk(16'h3FB5, 3'b000, LAT_NORM, "bp_next"));
    collect();
    handshake("bp_next");

    // Reset during ITER discards the operation
    issue(16'h42FE, mk(16'h7F00, 3'b000, LAT_NORM, "rst_dropped"));
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    sb.delete();
    #1;
    check("mid_rst:ready_o", 32'(ready_o), 32'd1);
    check("mid_rst:valid_o", 32'(valid_o), 32'd0);
    check("mid_rst:res_o", 32'(res_o), 32'h0);
    check("mid_rst:status_o", 32'(status_o), 32'h0);
    @(negedge clk);
    rst_i = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (valid_o) seen++;
    end
    check("mid_rst:no_result", seen, 32'd0);
    issue(16'h3F80, mk(16'h4000, 3'b000, LAT_NORM, "after_rst"));
    collect();
    handshake("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
